// File: rtl/rcpa_pkg.sv
// Shared definitions for the word-serial ripple-carry adder/subtractor.
// Holds the adder word width, FSM state encoding and operation encoding.
package rcpa_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

endpackage

// File: rtl/rcpa.sv
// 16-bit ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module rcpa
  import rcpa_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  // The carry is a block-local variable so the chain stays a simple ripple.
  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < WORD_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/rcpa_seq.sv
// Multi-word adder/subtractor that reuses one 16-bit ripple adder, one word per
// cycle LSW first, with valid/ready handshakes on both operand and result sides.
module rcpa_seq
  import rcpa_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
  input  logic                  op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int W     = WORD_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t            state;
  state_t            next_state;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  op_t               op_reg;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;

  // Subtraction is A + ~B + 1: the +1 comes from carry being seeded with 1.
  assign a_word = a_reg[idx*WORD_W +: WORD_W];
  assign b_word = (op_reg == OP_SUB) ? ~b_reg[idx*WORD_W +: WORD_W]
                                     :  b_reg[idx*WORD_W +: WORD_W];

  rcpa u_rcpa (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = S_ADD;
      end
      S_ADD: begin
        if (idx == LAST_IDX) next_state = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operands and op are captured only at acceptance; the result is only
  // touched in ADD, so it holds steady throughout DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= OP_ADD;
      idx    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op_t'(op);
            idx    <= '0;
            carry  <= (op_t'(op) == OP_SUB) ? 1'b1 : cin;
          end
        end
        S_ADD: begin
          sum[idx*WORD_W +: WORD_W] <= add_sum;
          carry <= add_cout;
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            cout <= add_cout;
            ovf  <= (a_reg[W-1] == b_word[WORD_W-1]) &&
                    (add_sum[WORD_W-1] != a_reg[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rcpa_seq.sv
// Randomized self-checking bench for rcpa_seq against a whole-operand
// arithmetic reference model, plus the directed corner cases.
module tb_rcpa_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  rcpa_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, got, want);
    end
  endtask

  // Whole-operand reference: plain wide arithmetic, overflow means the true
  // signed result does not fit in W signed bits.
  function automatic void refModel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                   input logic rcin, input logic rop,
                                   output logic [W-1:0] rs, output logic rc,
                                   output logic ro);
    logic [W:0]          full;
    logic signed [W+1:0] exact;
    logic signed [W+1:0] sa;
    logic signed [W+1:0] sb;
    sa = $signed({{2{ra[W-1]}}, ra});
    sb = $signed({{2{rb[W-1]}}, rb});
    if (!rop) begin
      full  = {1'b0, ra} + {1'b0, rb} + (W+1)'(rcin);
      exact = sa + sb + $signed((W+2)'(rcin));
      rc    = full[W];
    end else begin
      full  = {1'b0, ra} - {1'b0, rb};
      exact = sa - sb;
      rc    = (ra >= rb);
    end
    rs = full[W-1:0];
    ro = (exact != $signed({{2{rs[W-1]}}, rs}));
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction: accept, time the latency, check the result, hold it
  // in DONE for 'hold' cycles while new operands are offered, then handshake.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tcin, input logic top, input int hold);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           cycles;
    refModel(ta, tb, tcin, top, es, ec, eo);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; op = top; in_valid = 1'b1; out_ready = 1'b0;
    checkOutput("in_ready_idle", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = ~top;
    cin = ~tcin;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    checkOutput("busy_add", W'({busy, in_ready}), W'(2'b10));
    cycles = 1;
    in_valid = 1'b1;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      if (!out_valid) cycles++;
      else break;
    end
    in_valid = 1'b0;
    checkOutput("latency", W'(cycles), W'(WORDS));
    checkOutput("sum", sum, es);
    checkOutput("cout", W'(cout), W'(ec));
    checkOutput("ovf", W'(ovf), W'(eo));
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_state", W'({out_valid, in_ready, busy}), W'(3'b101));
      checkOutput("hold_sum", sum, es);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_handshake", W'({out_valid, in_ready, busy}), W'(3'b010));
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;
    doReset();
    #1;
    checkOutput("reset_flags", W'({in_ready, out_valid, busy, cout, ovf}), W'(5'b10000));
    checkOutput("reset_sum", sum, '0);

    applyStimulus(64'h158A, 64'h7095, 1'b0, 1'b0, 0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1);
    applyStimulus(64'h52AF, 64'hB903, 1'b0, 1'b1, 0);
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 2);
    applyStimulus(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 3);
    applyStimulus(64'h1234, 64'h1234, 1'b0, 1'b1, 3);

    // Reset in the second ADD cycle must abort with no result.
    @(negedge clk);
    a = 64'h1111_2222_3333_4444; b = 64'h5555; cin = 1'b1; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_flags", W'({in_ready, out_valid, busy}), W'(3'b100));
    checkOutput("abort_sum", sum, '0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("abort_no_result", W'(seen), '0);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) ra = '1;
      if ($urandom_range(0, 5) == 0) rb = {1'b1, {(W-1){1'b0}}};
      applyStimulus(ra, rb, 1'(($urandom)), 1'(($urandom)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rcpa_seq.md
RCPA_SEQ -- requirements
Module: rcpa_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of 16-bit words per operand (operand width W = 16*WORDS).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operands and op are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port a, input, W bits: operand A.
REQ-007 SHALL have port b, input, W bits: operand B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in, used only for add.
REQ-009 SHALL have port op, input, 1 bit: 0 = A+B+cin, 1 = A-B.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port sum, output, W bits: the result.
REQ-013 SHALL have port cout, output, 1 bit: final carry-out (1 = no borrow on subtract).
REQ-014 SHALL have port ovf, output, 1 bit: signed overflow.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL compute the W-bit result with one shared 16-bit ripple-carry adder, one word per cycle, LSW first.
REQ-017 SHALL implement an FSM with states IDLE, ADD and DONE.
REQ-018 IDLE SHALL drive in_ready=1; on in_valid&in_ready it SHALL register a, b and op, set idx=0, set carry=cin when op=0 or carry=1 when op=1, and go to ADD.
REQ-019 ADD SHALL feed a[idx], b[idx] (b word bitwise inverted when op=1) and carry to the adder, write its sum into sum word idx, set carry to the adder cout, and increment idx.
REQ-020 ADD SHALL go to DONE on the edge that processes idx==WORDS-1, so out_valid rises exactly WORDS cycles after the accepting edge.
REQ-021 DONE SHALL drive out_valid=1 and hold sum, cout and ovf stable until out_valid&out_ready, then go to IDLE.
REQ-022 in_ready SHALL be 0 in ADD and DONE; in_valid in those states SHALL be ignored and no operand SHALL be dropped or overwritten.
REQ-023 SHALL NOT accept a new operation in the same cycle as the DONE handshake (minimum issue interval WORDS+2 cycles).
REQ-024 ovf SHALL equal (A msb == effective-B msb) AND (sum msb != A msb), evaluated on the registered operands.
REQ-025 Wrap-around SHALL be modulo 2^W, with the carry out of the top word reported on cout.
REQ-026 op SHALL be sampled only at acceptance; later changes to op SHALL NOT affect an operation in flight.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL enter IDLE with sum=0, cout=0, ovf=0, out_valid=0, busy=0, idx=0 and carry=0, and with in_ready=1 after the edge.
REQ-028 Reset during ADD or DONE SHALL abort the operation silently, with no out_valid pulse.

Structure
REQ-029 SHALL define WORD_W=16, the state encoding and the op encoding in a shared package, rcpa_pkg.
REQ-030 SHALL instantiate the existing 16-bit adder, rcpa, as its single sub-module; no other adder logic is permitted.

Verification
REQ-031 a=0x158A, b=0x7095, cin=0, op=0 SHALL give sum=0x0000_0000_0000_861F, cout=0, ovf=0, with out_valid 4 cycles after acceptance.
REQ-032 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 SHALL give sum=0, cout=1, ovf=0 (carry ripples through all words).
REQ-033 a=0x52AF, b=0xB903, op=1 SHALL give sum=0xFFFF_FFFF_FFFF_99AC, cout=0, ovf=0.
REQ-034 a=0x7FFF_FFFF_FFFF_FFFF, b=1, op=0, cin=0 SHALL give sum=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-035 With out_ready held 0 for 3 cycles in DONE while in_valid=1 with new operands, sum and out_valid SHALL be held, in_ready SHALL stay 0, and the new operands SHALL be accepted only after returning to IDLE.
REQ-036 rst pulsed during the 2nd ADD cycle SHALL put the block in IDLE next cycle with sum=0, out_valid=0, busy=0 and no result emitted.
